// File: rtl/operand_loader_if.sv
// Operand loader bus: switch/load/handshake inputs and registered operand outputs.
//   sw_data[4:0], sw_cin  : operand value and carry-in to capture
//   load, clear, ack      : load request level, sequence abandon, downstream consumed
//   a0..a4, b0..b4, cin   : registered operand A, operand B, carry-in (bit 0 = LSB)
//   op_valid              : complete, stable operand set present
//   state[1:0]            : current FSM encoding for LED display
// master = stimulus side, slave = operand_loader side.
interface operand_loader_if;
  logic [4:0] sw_data;
  logic       sw_cin;
  logic       load;
  logic       clear;
  logic       ack;
  logic       a0, a1, a2, a3, a4;
  logic       b0, b1, b2, b3, b4;
  logic       cin;
  logic       op_valid;
  logic [1:0] state;

  modport master (
    output sw_data, sw_cin, load, clear, ack,
    input  a0, a1, a2, a3, a4, b0, b1, b2, b3, b4, cin, op_valid, state
  );

  modport slave (
    input  sw_data, sw_cin, load, clear, ack,
    output a0, a1, a2, a3, a4, b0, b1, b2, b3, b4, cin, op_valid, state
  );
endinterface

// File: rtl/operand_loader.sv
// operand_loader: captures two 5-bit operands and a carry-in from switches on
// successive load rising edges, then holds them (op_valid) until the downstream
// adder acknowledges.
// Ports:
//   clk    : clock, all state updates on rising edge
//   rst_n  : synchronous active-low reset (priority over clear)
//   bus    : operand_loader_if.slave (sw_data, sw_cin, load, clear, ack in;
//            a0..a4, b0..b4, cin, op_valid, state out)
// Parameter DB_CYCLES: stable cycles required by the load debouncer.
// Optional macro LOAD_DEBOUNCE_EN: adds a 2-flop synchronizer and counter
// filter on load; without it, edge detection acts on raw load.
module operand_loader #(
  parameter int unsigned DB_CYCLES = 4
) (
  input logic              clk,
  input logic              rst_n,
  operand_loader_if.slave  bus
);

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    FULL   = 2'b10
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_load_q;
  logic       w_load_lvl;
  logic       w_load_edge;
  logic       w_cap_a;
  logic       w_cap_b;
  logic [4:0] r_a;
  logic [4:0] r_b;
  logic       r_cin;

`ifdef LOAD_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DB_CYCLES + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_filt;
  logic [CW-1:0] r_db_cnt;

  // Filtered level flips on the DB_CYCLES-th consecutive clock on which the
  // synchronized level disagrees with it; any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_filt   <= 1'b0;
      r_db_cnt <= '0;
    end else begin
      r_sync1 <= bus.load;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_filt) begin
        if (r_db_cnt == CW'(DB_CYCLES - 1)) begin
          r_filt   <= r_sync2;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  assign w_load_lvl = r_filt;
`else
  logic w_unused_db;
  assign w_unused_db = |DB_CYCLES;
  assign w_load_lvl  = bus.load;
`endif

  assign w_load_edge = w_load_lvl & ~r_load_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= LOAD_A;
      r_load_q <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_load_q <= w_load_lvl;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_cap_a = 1'b0;
    w_cap_b = 1'b0;
    if (bus.clear) begin
      w_next = LOAD_A;
    end else begin
      case (r_state)
        LOAD_A: if (w_load_edge) begin
          w_cap_a = 1'b1;
          w_next  = LOAD_B;
        end
        LOAD_B: if (w_load_edge) begin
          w_cap_b = 1'b1;
          w_next  = FULL;
        end
        // Load edges are ignored here, including one coincident with ack.
        FULL:   if (bus.ack) w_next = LOAD_A;
        default: w_next = LOAD_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || bus.clear) begin
      r_a   <= '0;
      r_b   <= '0;
      r_cin <= 1'b0;
    end else begin
      if (w_cap_a) r_a <= bus.sw_data;
      if (w_cap_b) begin
        r_b   <= bus.sw_data;
        r_cin <= bus.sw_cin;
      end
    end
  end

  assign bus.a0       = r_a[0];
  assign bus.a1       = r_a[1];
  assign bus.a2       = r_a[2];
  assign bus.a3       = r_a[3];
  assign bus.a4       = r_a[4];
  assign bus.b0       = r_b[0];
  assign bus.b1       = r_b[1];
  assign bus.b2       = r_b[2];
  assign bus.b3       = r_b[3];
  assign bus.b4       = r_b[4];
  assign bus.cin      = r_cin;
  // FULL is entered exactly when the set completes and left on ack/clear/reset.
  assign bus.op_valid = (r_state == FULL);
  assign bus.state    = r_state;

endmodule

// File: tb/tb_operand_loader.sv
module tb_operand_loader;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  operand_loader_if u_if ();

  operand_loader #(.DB_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  typedef struct {
    logic       rst_n, clr, ack, load;
    logic [4:0] sw;
    logic       ci;
    logic [4:0] ea, eb;
    logic       ecin, ev;
    logic [1:0] es;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic c, logic k, logic l, logic [4:0] sw, logic ci,
                              logic [4:0] ea, logic [4:0] eb, logic ecin, logic ev, logic [1:0] es);
    vec_t v;
    v.rst_n = r; v.clr = c; v.ack = k; v.load = l; v.sw = sw; v.ci = ci;
    v.ea = ea; v.eb = eb; v.ecin = ecin; v.ev = ev; v.es = es;
    return v;
  endfunction

  function automatic logic [13:0] outs();
    return {u_if.a4, u_if.a3, u_if.a2, u_if.a1, u_if.a0,
            u_if.b4, u_if.b3, u_if.b2, u_if.b1, u_if.b0,
            u_if.cin, u_if.op_valid, u_if.state};
  endfunction

  task automatic apply(input logic r, input logic c, input logic k, input logic l,
                       input logic [4:0] sw, input logic ci);
    @(negedge clk);
    rst_n        = r;
    u_if.clear   = c;
    u_if.ack     = k;
    u_if.load    = l;
    u_if.sw_data = sw;
    u_if.sw_cin  = ci;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [13:0] exp);
    logic [13:0] got;
    got = outs();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got a=%b b=%b cin=%b v=%b st=%b exp a=%b b=%b cin=%b v=%b st=%b",
               nm, got[13:9], got[8:4], got[3], got[2], got[1:0],
               exp[13:9], exp[8:4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    u_if.clear   = 1'b0;
    u_if.ack     = 1'b0;
    u_if.load    = 1'b0;
    u_if.sw_data = '0;
    u_if.sw_cin  = 1'b0;

`ifndef LOAD_DEBOUNCE_EN
    //            rst clr ack ld  sw        ci    ea        eb        ec  v  st
    vecs.push_back(mk(0, 0, 0, 0, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 2'b00));
    vecs.push_back(mk(1, 0, 0, 0, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 2'b00));
    vecs.push_back(mk(1, 0, 0, 1, 5'b10110, 0, 5'b10110, 5'b00000, 0, 0, 2'b01));
    vecs.push_back(mk(1, 0, 0, 0, 5'b01011, 1, 5'b10110, 5'b00000, 0, 0, 2'b01));
    vecs.push_back(mk(1, 0, 0, 1, 5'b01011, 1, 5'b10110, 5'b01011, 1, 1, 2'b10));
    vecs.push_back(mk(1, 0, 0, 0, 5'b11111, 0, 5'b10110, 5'b01011, 1, 1, 2'b10));
    vecs.push_back(mk(1, 0, 0, 1, 5'b11111, 0, 5'b10110, 5'b01011, 1, 1, 2'b10));
    vecs.push_back(mk(1, 0, 0, 0, 5'b11111, 0, 5'b10110, 5'b01011, 1, 1, 2'b10));
    vecs.push_back(mk(1, 0, 1, 0, 5'b11111, 0, 5'b10110, 5'b01011, 1, 0, 2'b00));
    vecs.push_back(mk(1, 0, 0, 0, 5'b11111, 0, 5'b10110, 5'b01011, 1, 0, 2'b00));
    vecs.push_back(mk(1, 0, 1, 0, 5'b11111, 0, 5'b10110, 5'b01011, 1, 0, 2'b00));
    vecs.push_back(mk(1, 0, 0, 1, 5'b00111, 0, 5'b00111, 5'b01011, 1, 0, 2'b01));
    vecs.push_back(mk(1, 0, 1, 0, 5'b00111, 0, 5'b00111, 5'b01011, 1, 0, 2'b01));
    vecs.push_back(mk(1, 1, 0, 1, 5'b11001, 1, 5'b00000, 5'b00000, 0, 0, 2'b00));
    vecs.push_back(mk(1, 0, 0, 0, 5'b11001, 1, 5'b00000, 5'b00000, 0, 0, 2'b00));
    vecs.push_back(mk(1, 0, 0, 1, 5'b00001, 0, 5'b00001, 5'b00000, 0, 0, 2'b01));
    vecs.push_back(mk(1, 0, 0, 0, 5'b00010, 0, 5'b00001, 5'b00000, 0, 0, 2'b01));
    vecs.push_back(mk(1, 0, 0, 1, 5'b00010, 0, 5'b00001, 5'b00010, 0, 1, 2'b10));
    vecs.push_back(mk(1, 0, 0, 0, 5'b11100, 1, 5'b00001, 5'b00010, 0, 1, 2'b10));
    vecs.push_back(mk(1, 0, 1, 1, 5'b11100, 1, 5'b00001, 5'b00010, 0, 0, 2'b00));
    vecs.push_back(mk(1, 0, 0, 1, 5'b11100, 1, 5'b00001, 5'b00010, 0, 0, 2'b00));
    vecs.push_back(mk(1, 0, 0, 0, 5'b10000, 0, 5'b00001, 5'b00010, 0, 0, 2'b00));
    vecs.push_back(mk(1, 0, 0, 1, 5'b10000, 0, 5'b10000, 5'b00010, 0, 0, 2'b01));
    vecs.push_back(mk(1, 0, 0, 0, 5'b00100, 1, 5'b10000, 5'b00010, 0, 0, 2'b01));
    vecs.push_back(mk(1, 0, 0, 1, 5'b00100, 1, 5'b10000, 5'b00100, 1, 1, 2'b10));
    vecs.push_back(mk(1, 1, 1, 0, 5'b00100, 1, 5'b00000, 5'b00000, 0, 0, 2'b00));
    vecs.push_back(mk(1, 0, 0, 1, 5'b01010, 0, 5'b01010, 5'b00000, 0, 0, 2'b01));
    vecs.push_back(mk(1, 0, 0, 0, 5'b00110, 1, 5'b01010, 5'b00000, 0, 0, 2'b01));
    vecs.push_back(mk(1, 0, 0, 1, 5'b00110, 1, 5'b01010, 5'b00110, 1, 1, 2'b10));
    vecs.push_back(mk(0, 1, 0, 0, 5'b00110, 1, 5'b00000, 5'b00000, 0, 0, 2'b00));
    vecs.push_back(mk(1, 0, 0, 0, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 2'b00));

    foreach (vecs[i]) begin
      apply(vecs[i].rst_n, vecs[i].clr, vecs[i].ack, vecs[i].load, vecs[i].sw, vecs[i].ci);
      chk($sformatf("vec%0d", i),
          {vecs[i].ea, vecs[i].eb, vecs[i].ecin, vecs[i].ev, vecs[i].es});
    end

    // Held-high load in LOAD_A: one capture, then parked in LOAD_B.
    for (int unsigned n = 0; n < 20; n++) begin
      apply(1, 0, 0, 1, 5'b00011, 0);
      chk($sformatf("hold%0d", n), {5'b00011, 5'b00000, 1'b0, 1'b0, 2'b01});
    end
    apply(1, 0, 0, 0, 5'b00011, 0);
    chk("hold_release", {5'b00011, 5'b00000, 1'b0, 1'b0, 2'b01});
`else
    apply(0, 0, 0, 0, 5'b00000, 0);
    apply(0, 0, 0, 0, 5'b00000, 0);
    chk("db_reset", 14'd0);
    // Short pulse must be filtered out.
    for (int unsigned n = 0; n < 3; n++) apply(1, 0, 0, 1, 5'b11111, 0);
    for (int unsigned n = 0; n < 10; n++) apply(1, 0, 0, 0, 5'b11111, 0);
    chk("db_short", 14'd0);
    // Long pulse: capture at the 7th edge, 6 cycles after the rise is sampled.
    for (int unsigned n = 0; n < 6; n++) apply(1, 0, 0, 1, 5'b10101, 0);
    chk("db_before", 14'd0);
    apply(1, 0, 0, 1, 5'b10101, 0);
    chk("db_capture", {5'b10101, 5'b00000, 1'b0, 1'b0, 2'b01});
    for (int unsigned n = 0; n < 3; n++) apply(1, 0, 0, 1, 5'b10101, 0);
    for (int unsigned n = 0; n < 10; n++) apply(1, 0, 0, 0, 5'b10101, 0);
    chk("db_after", {5'b10101, 5'b00000, 1'b0, 1'b0, 2'b01});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_loader.md
OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 The block SHALL have one parameter: DB_CYCLES, default 4, the number of consecutive stable cycles the load debouncer requires (used only when LOAD_DEBOUNCE_EN is defined).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port sw_data, input, 5 bits: operand value to be captured.
REQ-005 The block SHALL have port sw_cin, input, 1 bit: carry-in value, captured together with operand B.
REQ-006 The block SHALL have port load, input, 1 bit: load request level; action is taken on its rising edge only.
REQ-007 The block SHALL have port clear, input, 1 bit: synchronous abandon of the current load sequence.
REQ-008 The block SHALL have port ack, input, 1 bit: downstream adder stage has consumed the operand pair.
REQ-009 The block SHALL have ports a0..a4, outputs, 1 bit each: registered operand A bits, a0 = LSB.
REQ-010 The block SHALL have ports b0..b4, outputs, 1 bit each: registered operand B bits, b0 = LSB.
REQ-011 The block SHALL have port cin, output, 1 bit: registered carry-in for the downstream adder.
REQ-012 The block SHALL have port op_valid, output, 1 bit: a0..a4, b0..b4 and cin hold a complete, stable operand set.
REQ-013 The block SHALL have port state, output, 2 bits: current FSM encoding, for LED display.

Function
REQ-014 Edge detection SHALL use a registered copy load_q; load_edge = load AND NOT load_q, computed on the conditioned load signal.
REQ-015 The FSM SHALL have three states: LOAD_A (2'b00), LOAD_B (2'b01) and FULL (2'b10); 2'b11 is illegal and SHALL return to LOAD_A on the next clock.
REQ-016 In LOAD_A, a load_edge SHALL capture sw_data into a4..a0 at that clock edge and move to LOAD_B.
REQ-017 In LOAD_B, a load_edge SHALL capture sw_data into b4..b0 and sw_cin into cin at that clock edge, move to FULL, and assert op_valid at the same edge.
REQ-018 In FULL, op_valid SHALL stay high and the outputs SHALL stay unchanged until ack is high at a clock edge, which then moves to LOAD_A and deasserts op_valid.
REQ-019 In FULL, load edges SHALL be ignored; an edge arriving in the same cycle as ack SHALL also be ignored, and A SHALL NOT be captured.
REQ-020 ack SHALL have no effect in LOAD_A or LOAD_B.
REQ-021 Operand outputs SHALL keep their last values after ack until the next capture overwrites them.
REQ-022 clear high at a clock edge SHALL, from any state, move to LOAD_A, zero a0..a4, b0..b4 and cin, and deassert op_valid; clear SHALL take priority over load and ack.
REQ-023 A held-high load SHALL produce exactly one capture.
REQ-024 Without debounce, latency from the load rising edge being sampled to output update SHALL be 0 cycles, with the update occurring at that same clock edge.

Reset
REQ-025 While rst_n is low at a clock edge, the FSM SHALL be LOAD_A, all operand outputs and cin SHALL be 0, op_valid SHALL be 0, state SHALL be 2'b00, and load_q and the debouncer state SHALL be 0.
REQ-026 Reset asserted mid-sequence, including in FULL, SHALL discard the partial or complete operand set; rst_n SHALL take priority over clear.

Configuration
REQ-027 With LOAD_DEBOUNCE_EN defined, load SHALL pass through a 2-flop synchronizer followed by a counter filter; the filtered level SHALL change only after the synchronized level differs from it for DB_CYCLES consecutive clocks, and edge detection SHALL use the filtered level.
REQ-028 With LOAD_DEBOUNCE_EN defined, capture latency from the load rise SHALL be 2 + DB_CYCLES cycles, and pulses shorter than DB_CYCLES SHALL be ignored.
REQ-029 Without LOAD_DEBOUNCE_EN, the synchronizer and filter SHALL be absent, edge detection SHALL act on raw load, and DB_CYCLES SHALL be unused.

Verification
REQ-030 Reset then sequence: sw_data=5'b10110 plus a load pulse, then sw_data=5'b01011 and sw_cin=1 plus a load pulse -> a4..a0=10110, b4..b0=01011, cin=1, op_valid=1, state=2'b10.
REQ-031 From FULL, a load pulse with sw_data=5'b11111 and no ack -> outputs and op_valid unchanged; then ack for 1 cycle -> op_valid=0, state=2'b00, A and B still hold 10110 and 01011.
REQ-032 In LOAD_B, clear and load high at the same edge -> state=2'b00, all operands 0, op_valid=0.
REQ-033 load held high for 20 cycles in LOAD_A with sw_data=5'b00011 -> exactly one capture, state=2'b01 and remaining there.
REQ-034 rst_n=0 for 1 cycle while in FULL -> all outputs 0 and state=2'b00 at the next edge.
REQ-035 With LOAD_DEBOUNCE_EN and DB_CYCLES=4: a 3-cycle load pulse -> no capture; a 10-cycle pulse -> capture 6 cycles after the rise.
